tis_stream_checker: RTL and testbench
=====================================

// Module: tis_stream_checker
// PURPOSE
//  Parametrised self-checking sink for core-complex output ports. Accepts NCH independent
//  11-bit TIS output streams over the rready/read handshake and compares each word against
//  a preloaded expected sequence. Keeps per-lane correct/error counts and global done/pass.
//  Replaces ad-hoc sink instances and $display checks in benches; also synthesisable for FPGA.
// PARAMETERS
//  NCH    4   number of output lanes checked
//  DEPTH  39  max expected words per lane (expected memory depth)
//  CW     8   width of per-lane correct/error counters (saturating)
// PORTS
//  clk          in   1            system clock, rising edge
//  rst_n        in   1            async active-low reset
//  ld_we        in   1            expected-memory write strobe (honoured in IDLE/DONE only)
//  ld_ch        in   $clog2(NCH)  lane for load
//  ld_idx       in   $clog2(DEPTH) word index for load
//  ld_data      in   11           expected word, signed
//  ld_len       in   NCH*$clog2(DEPTH+1) per-lane expected length, sampled on start
//  start        in   1            pulse: clear counters, enter RUN
//  rready       in   NCH          producer has a word on in[ch]
//  in           in   NCH*11       producer data, signed two's complement
//  read         out  NCH          acknowledge pulse to producer
//  correct_cnt  out  NCH*CW       words matching expectation
//  err_cnt      out  NCH*CW       mismatching or out-of-range words
//  done         out  1            every lane received its full length
//  pass         out  1            done && all err_cnt == 0
// BEHAVIOUR
//  Reset: read=0, counts=0, lane indices=0, done=0, pass=0, top FSM IDLE. Expected memory has no reset; contents survive rst_n.
//  Top FSM: IDLE -start-> RUN (latch ld_len, clear counts/indices) ; RUN -all lanes idx==len-> DONE ;
//   DONE -start-> RUN (restart, same memory). start in RUN ignored. ld_we in RUN ignored.
//  Lane FSM (per ch, only active in RUN): WAIT -> ACK -> WAIT.
//   WAIT: if rready[ch] && idx<len: capture in[ch], go ACK. read[ch] rises the cycle after
//   rready is sampled (1-cycle latency), stays high exactly one cycle.
//   ACK: compare captured word vs exp[ch][idx]; match and |word|<=999 -> correct_cnt++,
//   else err_cnt++; idx++. Producer must drop rready on seeing read; WAIT will not re-sample
//   in the same cycle read is high, so minimum accept period is 2 cycles per word.
//  Excess words (idx==len): never acknowledged; producer stalls; lane stays complete.
//  len==0: lane complete immediately at start. All lanes len==0 -> done one cycle after start.
//  Counters saturate at 2**CW-1 (no wrap). Comparison is full 11-bit signed equality;
//   -1000..-1024 and 1000..1023 count as errors even if expected memory holds the same value.
//  done/pass registered: asserted the cycle after last lane's final ACK; held until start or reset.
//  Simultaneous start and ld_we in IDLE: load completes in that cycle, run uses new word only from next read.
//  rst_n asserted mid-RUN: read drops asynchronously, in-flight word discarded, FSM to IDLE.
// CONFIGURATION
//  TIS_CHECKER_STALL_EN defined: 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset)
//   per lane gates WAIT->ACK; when lfsr[0]==0 the lane withholds acceptance that cycle,
//   emulating random back-pressure. Counts/results identical to unstalled run, only timing differs.
//  Undefined: no LFSR; accept on first cycle rready is seen (latency exactly 1).
// STRUCTURE
//  tis_pkg: typedef logic signed [10:0] tis_word_t; localparam TIS_MAX=999, TIS_MIN=-999;
//   typedef enum {CHK_IDLE, CHK_RUN, CHK_DONE} chk_state_t; enum {LANE_WAIT, LANE_ACK}.
//  Sub-module tis_check_lane (one per lane, generate loop): lane FSM, capture reg, compare,
//   counters, optional LFSR. Top holds expected memory, top FSM, done/pass reduction.
// TESTING
//  1 NCH=4, len={3,3,3,3}, all producers send expected {5,-7,999} -> correct_cnt=3 each, err=0, done=1, pass=1.
//  2 lane 2 sends {5,-8,999} vs {5,-7,999} -> lane2 correct=2 err=1, pass=0, other lanes pass.
//  3 lane 0 sends 1000 with expected 1000 loaded -> err_cnt[0]=1 (range check).
//  4 len[1]=2, producer holds rready after 2 words -> read[1] stays 0, done still asserts.
//  5 rst_n low mid-RUN during ACK -> read=0 immediately; restart with start gives same results as 1.
//  6 with TIS_CHECKER_STALL_EN, repeat 1 -> identical counts, read latency >=1 and varying per word.

Source files
------------

// File: rtl/tis_stream_checker_pkg.sv
// Shared types for the TIS stream checker: signed 11-bit word, legal value range, FSM states.
package tis_stream_checker_pkg;

  localparam int TIS_W   = 11;
  localparam int TIS_MAX = 999;
  localparam int TIS_MIN = -999;

  typedef logic signed [TIS_W-1:0] tis_word_t;

  typedef enum logic [1:0] {
    CHK_IDLE,
    CHK_RUN,
    CHK_DONE
  } chk_state_t;

  typedef enum logic {
    LANE_WAIT,
    LANE_ACK
  } lane_state_t;

  // A TIS word only counts as correct when it is inside the machine's legal range.
  function automatic logic tis_in_range(input tis_word_t w);
    return (int'(w) >= TIS_MIN) && (int'(w) <= TIS_MAX);
  endfunction

endpackage

// File: rtl/tis_stream_checker_if.sv
// Producer-to-checker stream bundle: per-lane rready/data from the producer, read acknowledge back.
interface tis_stream_checker_if #(
  parameter int NCH = 4
) ();
  import tis_stream_checker_pkg::*;

  logic [NCH-1:0]       rready;
  logic [NCH*TIS_W-1:0] in;
  logic [NCH-1:0]       read;

  modport master (output rready, output in, input read);
  modport slave  (input rready, input in, output read);

endinterface

// File: rtl/tis_stream_checker_lane.sv
// One checker lane: WAIT/ACK handshake, word capture, compare, saturating counters.
// TIS_CHECKER_STALL_EN adds an LFSR that randomly withholds acceptance (back-pressure).
module tis_stream_checker_lane
  import tis_stream_checker_pkg::*;
#(
  parameter int CW = 8,
  parameter int LW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          run,
  input  logic [LW-1:0] len,
  input  logic          rready,
  input  tis_word_t     data,
  input  tis_word_t     exp_word,
  output logic          read,
  output logic [LW-1:0] idx,
  output logic [CW-1:0] correct_cnt,
  output logic [CW-1:0] err_cnt,
  output logic          complete_next
);

  lane_state_t state_q, state_d;
  tis_word_t   cap_q;
  logic        accept_ok;
  logic        take;
  logic        ack;
  logic        hit;

`ifdef TIS_CHECKER_STALL_EN
  logic [15:0] lfsr_q;

  // x^16+x^14+x^13+x^11+1, right-shifting form; free-runs so stalls vary word to word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end

  assign accept_ok = lfsr_q[0];
`else
  assign accept_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    ack     = 1'b0;
    case (state_q)
      LANE_WAIT: begin
        if (run && rready && (idx < len) && accept_ok) begin
          state_d = LANE_ACK;
          take    = 1'b1;
        end
      end
      LANE_ACK: begin
        state_d = LANE_WAIT;
        ack     = 1'b1;
      end
      default: state_d = LANE_WAIT;
    endcase
    if (clear) begin
      state_d = LANE_WAIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LANE_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  assign hit = (cap_q == exp_word) && tis_in_range(cap_q);

  // Counters stick at all-ones instead of wrapping so a long bad run never looks clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q       <= '0;
      idx         <= '0;
      correct_cnt <= '0;
      err_cnt     <= '0;
    end else if (clear) begin
      idx         <= '0;
      correct_cnt <= '0;
      err_cnt     <= '0;
    end else begin
      if (take) begin
        cap_q <= data;
      end
      if (ack) begin
        idx <= idx + 1'b1;
        if (hit) begin
          if (correct_cnt != '1) correct_cnt <= correct_cnt + 1'b1;
        end else begin
          if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
      end
    end
  end

  assign read          = (state_q == LANE_ACK);
  assign complete_next = ((idx + LW'(ack)) == len);

endmodule

// File: rtl/tis_stream_checker.sv
// Self-checking sink for NCH TIS output streams against preloaded expected sequences.
// Optional TIS_CHECKER_STALL_EN enables random per-lane back-pressure inside each lane.
module tis_stream_checker
  import tis_stream_checker_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int DEPTH = 39,
  parameter int CW    = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ld_we,
  input  logic [$clog2(NCH)-1:0]           ld_ch,
  input  logic [$clog2(DEPTH)-1:0]         ld_idx,
  input  tis_word_t                        ld_data,
  input  logic [NCH*$clog2(DEPTH+1)-1:0]   ld_len,
  input  logic                             start,
  tis_stream_checker_if.slave              strm,
  output logic [NCH*CW-1:0]                correct_cnt,
  output logic [NCH*CW-1:0]                err_cnt,
  output logic                             done,
  output logic                             pass
);

  localparam int IW = $clog2(NCH);
  localparam int DW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  chk_state_t           state_q, state_d;
  logic                 go;
  logic                 mem_wr_ok;
  logic [NCH*LW-1:0]    len_q;
  logic [NCH-1:0]       lane_read;
  logic [NCH-1:0]       lane_complete_next;
  logic                 any_err;

  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    case (state_q)
      CHK_IDLE, CHK_DONE: begin
        if (start) begin
          state_d = CHK_RUN;
          go      = 1'b1;
        end
      end
      CHK_RUN: begin
        if (&lane_complete_next) begin
          state_d = CHK_DONE;
        end
      end
      default: state_d = CHK_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CHK_IDLE;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      if (go) begin
        len_q <= ld_len;
      end
    end
  end

  assign mem_wr_ok = ld_we && (state_q != CHK_RUN);

  for (genvar ch = 0; ch < NCH; ch++) begin : g_lane
    tis_word_t       mem [DEPTH];
    logic [LW-1:0]   idx;
    logic [DW-1:0]   rd_addr;
    tis_word_t       exp_word;

    // Expected memory is deliberately not reset so a sequence survives rst_n.
    always_ff @(posedge clk) begin
      if (mem_wr_ok && (ld_ch == IW'(ch)) && (int'(ld_idx) < DEPTH)) begin
        mem[ld_idx] <= ld_data;
      end
    end

    assign rd_addr  = idx[DW-1:0];
    assign exp_word = (int'(idx) < DEPTH) ? mem[rd_addr] : '0;

    tis_stream_checker_lane #(
      .CW (CW),
      .LW (LW)
    ) u_lane (
      .clk           (clk),
      .rst_n         (rst_n),
      .clear         (go),
      .run           (state_q == CHK_RUN),
      .len           (len_q[ch*LW +: LW]),
      .rready        (strm.rready[ch]),
      .data          (tis_word_t'(strm.in[ch*TIS_W +: TIS_W])),
      .exp_word      (exp_word),
      .read          (lane_read[ch]),
      .idx           (idx),
      .correct_cnt   (correct_cnt[ch*CW +: CW]),
      .err_cnt       (err_cnt[ch*CW +: CW]),
      .complete_next (lane_complete_next[ch])
    );
  end

  assign strm.read = lane_read;

  always_comb begin
    any_err = 1'b0;
    for (int ch = 0; ch < NCH; ch++) begin
      any_err = any_err | (|err_cnt[ch*CW +: CW]);
    end
  end

  assign done = (state_q == CHK_DONE);
  assign pass = done && !any_err;

endmodule

// File: tb/tb_tis_stream_checker.sv
// Randomised bench for tis_stream_checker against a per-lane count model built from the word lists.
module tb_tis_stream_checker;
  import tis_stream_checker_pkg::*;

  localparam int NCH   = 4;
  localparam int DEPTH = 39;
  localparam int CW    = 4;
  localparam int LW    = $clog2(DEPTH+1);
  localparam int IW    = $clog2(NCH);
  localparam int DW    = $clog2(DEPTH);
  localparam int SAT   = (1 << CW) - 1;
  localparam int MAXW  = DEPTH + 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                ld_we = 1'b0;
  logic [IW-1:0]       ld_ch = '0;
  logic [DW-1:0]       ld_idx = '0;
  tis_word_t           ld_data = '0;
  logic [NCH*LW-1:0]   ld_len = '0;
  logic                start = 1'b0;
  logic [NCH*CW-1:0]   correct_cnt;
  logic [NCH*CW-1:0]   err_cnt;
  logic                done;
  logic                pass;

  tis_stream_checker_if #(.NCH(NCH)) sif ();

  tis_stream_checker #(
    .NCH   (NCH),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_we       (ld_we),
    .ld_ch       (ld_ch),
    .ld_idx      (ld_idx),
    .ld_data     (ld_data),
    .ld_len      (ld_len),
    .start       (start),
    .strm        (sif),
    .correct_cnt (correct_cnt),
    .err_cnt     (err_cnt),
    .done        (done),
    .pass        (pass)
  );

  always #5 clk = ~clk;

  int expw  [NCH][MAXW];
  int sendw [NCH][MAXW];
  int lenv  [NCH];
  int nsend [NCH];
  int ptr   [NCH];
  int acks  [NCH];
  logic [NCH-1:0] prevRead;
  bit  prodOn;
  int  pulseViol;
  int  checks = 0;
  int  errors = 0;

  // Producers: present the next word until read is seen, then move on.
  always @(negedge clk) begin
    for (int ch = 0; ch < NCH; ch++) begin
      if (sif.read[ch] === 1'b1) begin
        acks[ch]++;
        ptr[ch]++;
        if (prevRead[ch]) pulseViol++;
      end
      prevRead[ch] = sif.read[ch];
      if (prodOn && ptr[ch] < nsend[ch]) begin
        sif.rready[ch] = 1'b1;
        sif.in[ch*TIS_W +: TIS_W] = tis_word_t'(sendw[ch][ptr[ch]]);
      end else begin
        sif.rready[ch] = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int modelCount(input int ch, input bit wantErr);
    int n, c, e;
    bit hit;
    n = (nsend[ch] < lenv[ch]) ? nsend[ch] : lenv[ch];
    c = 0;
    e = 0;
    for (int i = 0; i < n; i++) begin
      hit = (sendw[ch][i] == expw[ch][i]) && (sendw[ch][i] >= -999) && (sendw[ch][i] <= 999);
      if (hit) begin
        if (c < SAT) c++;
      end else begin
        if (e < SAT) e++;
      end
    end
    return wantErr ? e : c;
  endfunction

  function automatic int randWord();
    int r;
    r = int'($urandom_range(0, 15));
    if (r == 0) return int'($urandom_range(1000, 1023));
    if (r == 1) return -int'($urandom_range(1000, 1024));
    return int'($urandom_range(0, 1998)) - 999;
  endfunction

  task automatic setBasic();
    for (int ch = 0; ch < NCH; ch++) begin
      lenv[ch]  = 3;
      nsend[ch] = 3;
      expw[ch][0] = 5;  expw[ch][1] = -7;  expw[ch][2] = 999;
      sendw[ch][0] = 5; sendw[ch][1] = -7; sendw[ch][2] = 999;
    end
  endtask

  task automatic loadMemory();
    for (int ch = 0; ch < NCH; ch++) begin
      ld_len[ch*LW +: LW] = LW'(lenv[ch]);
      for (int i = 0; i < lenv[ch] && i < DEPTH; i++) begin
        @(negedge clk);
        ld_we   = 1'b1;
        ld_ch   = IW'(ch);
        ld_idx  = DW'(i);
        ld_data = tis_word_t'(expw[ch][i]);
      end
    end
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic resetProducers();
    @(posedge clk);
    #1;
    prodOn    = 1'b0;
    pulseViol = 0;
    prevRead  = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      ptr[ch]  = 0;
      acks[ch] = 0;
    end
  endtask

  task automatic checkResults(input string name);
    bit modelPass;
    int ackExp;
    modelPass = 1'b1;
    for (int ch = 0; ch < NCH; ch++) begin
      ackExp = (nsend[ch] < lenv[ch]) ? nsend[ch] : lenv[ch];
      checkOutput($sformatf("%s/l%0d/correct", name, ch), int'(correct_cnt[ch*CW +: CW]), modelCount(ch, 1'b0));
      checkOutput($sformatf("%s/l%0d/err", name, ch), int'(err_cnt[ch*CW +: CW]), modelCount(ch, 1'b1));
      checkOutput($sformatf("%s/l%0d/acks", name, ch), acks[ch], ackExp);
      if (modelCount(ch, 1'b1) != 0) modelPass = 1'b0;
    end
    checkOutput({name, "/done"}, int'(done), 1);
    checkOutput({name, "/pass"}, int'(pass), int'(modelPass));
    checkOutput({name, "/pulse"}, pulseViol, 0);
  endtask

  task automatic applyStimulus(input string name, input bit doLoad, input bit injectWrite);
    int cyc;
    if (doLoad) loadMemory();
    resetProducers();
    @(negedge clk);
    start  = 1'b1;
    prodOn = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (injectWrite) begin
      ld_we   = 1'b1;
      ld_ch   = IW'(3);
      ld_idx  = DW'(2);
      ld_data = tis_word_t'(0);
    end
    @(negedge clk);
    ld_we = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({name, "/done_wait"}, int'(done === 1'b1), 1);
    repeat (6) @(negedge clk);
    checkResults(name);
  endtask

  initial begin
    int cyc;
    sif.rready = '0;
    sif.in     = '0;
    prodOn     = 1'b0;
    pulseViol  = 0;
    prevRead   = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      ptr[ch] = 0; acks[ch] = 0; lenv[ch] = 0; nsend[ch] = 0;
    end

    repeat (3) @(negedge clk);
    checkOutput("reset/read", int'(sif.read), 0);
    checkOutput("reset/correct", int'(correct_cnt), 0);
    checkOutput("reset/err", int'(err_cnt), 0);
    checkOutput("reset/done", int'(done), 0);
    checkOutput("reset/pass", int'(pass), 0);
    rst_n = 1'b1;
    $display("[TB] reset released");

    setBasic();
    applyStimulus("basic", 1'b1, 1'b1);

    setBasic();
    sendw[2][1] = -8;
    applyStimulus("lane2_bad", 1'b1, 1'b0);

    setBasic();
    expw[0][0] = 1000;  sendw[0][0] = 1000;
    expw[1][1] = -1000; sendw[1][1] = -1000;
    applyStimulus("range", 1'b1, 1'b0);

    setBasic();
    lenv[1] = 2;
    applyStimulus("excess", 1'b1, 1'b0);
    checkOutput("excess/read1_low", int'(sif.read[1]), 0);

    // Abort mid-run while lane 0 is acknowledging, then rerun on the surviving memory.
    setBasic();
    loadMemory();
    resetProducers();
    @(negedge clk);
    start  = 1'b1;
    prodOn = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (sif.read[0] !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("midrst/read_seen", int'(sif.read[0] === 1'b1), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst/read", int'(sif.read), 0);
    checkOutput("midrst/correct", int'(correct_cnt), 0);
    checkOutput("midrst/done", int'(done), 0);
    prodOn = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("restart", 1'b0, 1'b0);

    // Long lanes push both counters into saturation.
    for (int ch = 0; ch < NCH; ch++) begin
      lenv[ch]  = (ch < 2) ? DEPTH : 0;
      nsend[ch] = lenv[ch];
      for (int i = 0; i < DEPTH; i++) begin
        expw[ch][i]  = int'($urandom_range(0, 1998)) - 999;
        sendw[ch][i] = (ch == 0) ? expw[ch][i] : ((expw[ch][i] == 0) ? 1 : -expw[ch][i]);
      end
    end
    applyStimulus("saturate", 1'b1, 1'b0);

    for (int ch = 0; ch < NCH; ch++) begin
      lenv[ch] = 0; nsend[ch] = 1; sendw[ch][0] = 5;
    end
    applyStimulus("all_zero", 1'b1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        lenv[ch]  = int'($urandom_range(0, DEPTH));
        nsend[ch] = lenv[ch] + (($urandom_range(0, 3) == 0) ? 1 : 0);
        for (int i = 0; i < nsend[ch]; i++) begin
          expw[ch][i]  = randWord();
          sendw[ch][i] = ($urandom_range(0, 3) != 0) ? expw[ch][i] : randWord();
        end
      end
      applyStimulus($sformatf("rand%0d", r), 1'b1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
